// File: rtl/rv32i_lsu_if.sv
// Word bus between the load/store unit and data memory.
// The LSU drives the request side; memory answers with gnt/rvalid/rdata.
interface rv32i_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rv32i_lsu.sv
// MEM-stage load/store unit for the rv32i pipeline.
// Turns byte/half/word loads and stores into single word-bus transactions
// with lane steering, write strobes and load extension. Misaligned or
// malformed accesses fault without touching the bus, and an access that
// gets no answer within TIMEOUT_CYCLES is abandoned with bus_err.
module rv32i_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        fault,
  output logic        bus_err,
  rv32i_lsu_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]    state;
  logic [CW-1:0] tmo_cnt;

  logic [29:0]   word_q;
  logic [1:0]    off_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;

  logic          start;
  logic          legal;
  logic          start_legal;
  logic          timeout;
  logic          success;
  logic          done;
  logic [3:0]    wstrb_d;
  logic [31:0]   wdata_d;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_data;

  assign start       = (state == IDLE) && ex_valid && (ex_memread || ex_memwrite);
  assign start_legal = start && legal;
  assign timeout     = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign success     = ((state == REQ) && bus.gnt && we_q) || ((state == WAIT) && bus.rvalid);
  assign done        = success || timeout;
  assign lsu_stall   = start_legal || ((state != IDLE) && !done);

  assign bus.req   = (state == REQ);
  assign bus.we    = we_q;
  assign bus.addr  = {word_q, 2'b00};
  assign bus.wstrb = wstrb_q;
  assign bus.wdata = wdata_q;

  // Decide whether the offered access is a well-formed, naturally aligned load or store.
  always_comb begin
    legal = 1'b0;
    if (ex_memread && !ex_memwrite) begin
      case (ex_funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = !ex_addr[0];
        3'b010:         legal = (ex_addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end else if (ex_memwrite && !ex_memread) begin
      case (ex_funct3)
        3'b000:  legal = 1'b1;
        3'b001:  legal = !ex_addr[0];
        3'b010:  legal = (ex_addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  // Steer store data onto every lane it may land in and enable only the addressed bytes.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = 32'h0000_0000;
    if (ex_memwrite) begin
      case (ex_funct3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << ex_addr[1:0];
          wdata_d = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          wstrb_d = ex_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{ex_wdata[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = ex_wdata;
        end
      endcase
    end
  end

  // Pick the addressed lane out of the returned word and sign- or zero-extend it.
  always_comb begin
    lane_b = bus.rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'h00_0000, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'h0000, lane_h};
      default: load_data = bus.rdata;
    endcase
  end

  // Access sequencer: latch on accept, hold the request until granted, collect read data or time out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      word_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      wb_valid <= 1'b0;
      wb_rdata <= '0;
      fault    <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      fault    <= start && !legal;
      bus_err  <= timeout && !success;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_legal) begin
            word_q   <= ex_addr[31:2];
            off_q    <= ex_addr[1:0];
            funct3_q <= ex_funct3;
            we_q     <= ex_memwrite;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            tmo_cnt  <= '0;
            state    <= REQ;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (bus.gnt && we_q) begin
            state <= IDLE;
          end else if (timeout) begin
            state <= IDLE;
          end else if (bus.gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (bus.rvalid) begin
            wb_rdata <= load_data;
            wb_valid <= 1'b1;
            state    <= IDLE;
          end else if (timeout) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: acts as both the EX/MEM stage and the
// data memory, predicting every output from a byte-level memory model.
module tb_rv32i_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        lsu_stall;
  logic        wb_valid;
  logic [31:0] wb_rdata;
  logic        fault;
  logic        bus_err;

  rv32i_lsu_if bus ();

  rv32i_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_funct3   (ex_funct3),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .lsu_stall   (lsu_stall),
    .wb_valid    (wb_valid),
    .wb_rdata    (wb_rdata),
    .fault       (fault),
    .bus_err     (bus_err),
    .bus         (bus.master)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        exp_stall, exp_req, exp_fault, exp_err, exp_wb, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic        pend_fault, pend_err, pend_wb;
  logic [31:0] pend_rdata;
  bit          check_en;
  bit          lit_en;
  logic [31:0] lit_addr, lit_wdata;
  logic [3:0]  lit_wstrb;

  logic [31:0] mem [logic [31:0]];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Loaded value from its word, byte offset and funct3, by plain arithmetic.
  function automatic logic [31:0] loadExtend(input logic [31:0] word, input int off, input logic [2:0] f3);
    logic [31:0] v;
    v = word >> (8 * off);
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // Advance one cycle; mode 0 quiet, 1 idle noise (no start, random bus), 2 busy (random ex_*).
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    exp_fault = pend_fault;
    exp_err   = pend_err;
    exp_wb    = pend_wb;
    if (pend_wb) exp_rdata = pend_rdata;
    pend_fault = 1'b0;
    pend_err   = 1'b0;
    pend_wb    = 1'b0;
    exp_stall  = 1'b0;
    exp_req    = 1'b0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = $urandom;
    ex_addr    = $urandom;
    ex_wdata   = $urandom;
    ex_funct3  = 3'($urandom);
    ex_valid    = 1'b0;
    ex_memread  = 1'b0;
    ex_memwrite = 1'b0;
    if (mode == 1) begin
      ex_valid = 1'($urandom);
      if (!ex_valid) begin
        ex_memread  = 1'($urandom);
        ex_memwrite = 1'($urandom);
      end
      bus.gnt    = 1'($urandom);
      bus.rvalid = 1'($urandom);
    end else if (mode == 2) begin
      ex_valid    = 1'($urandom);
      ex_memread  = 1'($urandom);
      ex_memwrite = 1'($urandom);
    end
  endtask

  // Offer one access and play memory; noresp 1 withholds gnt, 2 withholds rvalid.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int gd, input int rvd, input int noresp);
    int          nb, off, n, wcnt;
    bit          legal, phase, fin;
    logic [31:0] word;
    step(1);
    ex_valid = 1'b1; ex_memread = rd; ex_memwrite = wr;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
    nb  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(a % 4);
    if (rd && !wr)      legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else if (wr && !rd) legal = (f3 inside {3'd0, 3'd1, 3'd2});
    else                legal = 1'b0;
    legal = legal && ((a % nb) == 0);
    if (!legal) begin
      pend_fault = 1'b1;
    end else begin
      exp_stall = 1'b1;
      exp_addr  = a & ~32'h3;
      exp_we    = wr;
      if (wr) begin
        exp_wstrb = 4'(((1 << nb) - 1) << off);
        exp_wdata = (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                    (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      end else begin
        exp_wstrb = 4'b0000;
        exp_wdata = 32'h0;
      end
      n = 0; wcnt = 0; phase = 1'b0; fin = 1'b0;
      while (!fin) begin
        step(2);
        n++;
        if (!phase) begin
          exp_req = 1'b1;
          if (noresp != 1 && wcnt == gd) begin
            bus.gnt = 1'b1;
            if (wr) begin
              fin  = 1'b1;
              word = memRead(exp_addr);
              for (int i = 0; i < 4; i++)
                if (exp_wstrb[i]) word[8*i +: 8] = exp_wdata[8*i +: 8];
              mem[exp_addr] = word;
            end else begin
              phase = 1'b1; wcnt = 0; exp_stall = 1'b1;
            end
          end else begin
            exp_stall  = 1'b1;
            wcnt++;
            bus.rvalid = 1'($urandom);
          end
        end else begin
          bus.gnt = 1'($urandom);
          if (noresp != 2 && wcnt == rvd) begin
            word       = memRead(exp_addr);
            bus.rvalid = 1'b1;
            bus.rdata  = word;
            pend_wb    = 1'b1;
            pend_rdata = loadExtend(word, off, f3);
            fin        = 1'b1;
          end else begin
            exp_stall = 1'b1;
            wcnt++;
          end
        end
        if (!fin && n == TMO) begin
          exp_stall = 1'b0;
          pend_err  = 1'b1;
          fin       = 1'b1;
        end
      end
    end
  endtask

  // Every cycle, compare the DUT against the model's expectations.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
      checkOutput("bus_req",   32'(bus.req),   32'(exp_req));
      checkOutput("fault",     32'(fault),     32'(exp_fault));
      checkOutput("bus_err",   32'(bus_err),   32'(exp_err));
      checkOutput("wb_valid",  32'(wb_valid),  32'(exp_wb));
      checkOutput("wb_rdata",  wb_rdata,       exp_rdata);
      if (exp_req) begin
        checkOutput("bus_addr",  bus.addr,         exp_addr);
        checkOutput("bus_we",    32'(bus.we),      32'(exp_we));
        checkOutput("bus_wstrb", 32'(bus.wstrb),   32'(exp_wstrb));
        if (exp_we) checkOutput("bus_wdata", bus.wdata, exp_wdata);
      end
      if (lit_en && exp_req) begin
        checkOutput("lit_sh_addr",  bus.addr,       lit_addr);
        checkOutput("lit_sh_wstrb", 32'(bus.wstrb), 32'(lit_wstrb));
        checkOutput("lit_sh_wdata", bus.wdata,      lit_wdata);
        checkOutput("lit_sh_we",    32'(bus.we),    32'd1);
      end
    end
  end

  // Hard stop if the run ever wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases, randomized traffic, then reset during an outstanding load.
  initial begin
    int          r, off, gd, rvd;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    reset = 1'b1;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_funct3 = 3'b0; ex_addr = 32'h0; ex_wdata = 32'h0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    exp_stall = 0; exp_req = 0; exp_fault = 0; exp_err = 0; exp_wb = 0; exp_we = 0;
    exp_rdata = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
    pend_fault = 0; pend_err = 0; pend_wb = 0; pend_rdata = 0;
    check_en = 0; lit_en = 0;
    lit_addr = 32'h100; lit_wstrb = 4'b1100; lit_wdata = 32'hABCD_ABCD;
    mem[32'h100] = 32'h80FF_7F01;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall",    32'(lsu_stall), 0);
    checkOutput("rst_wb_valid", 32'(wb_valid),  0);
    checkOutput("rst_wb_rdata", wb_rdata,       0);
    checkOutput("rst_fault",    32'(fault),     0);
    checkOutput("rst_bus_err",  32'(bus_err),   0);
    checkOutput("rst_bus_req",  32'(bus.req),   0);
    checkOutput("rst_bus_we",   32'(bus.we),    0);
    checkOutput("rst_bus_addr", bus.addr,       0);
    checkOutput("rst_bus_wstrb",32'(bus.wstrb), 0);
    checkOutput("rst_bus_wdata",bus.wdata,      0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1'b1;

    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 1, 0);
    step(1); @(negedge clk);
    checkOutput("lit_lb_103", wb_rdata, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 0);
    step(1); @(negedge clk);
    checkOutput("lit_lbu_103", wb_rdata, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 2, 0);
    step(1); @(negedge clk);
    checkOutput("lit_lh_102", wb_rdata, 32'hFFFF_80FF);

    lit_en = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 2, 0, 0);
    step(1);
    lit_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 0);
    step(1); @(negedge clk);
    checkOutput("lit_lw_after_sh", wb_rdata, 32'hABCD_7F01);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 0);
    step(1); @(negedge clk);
    checkOutput("lit_lw_101_fault", 32'(fault), 1);
    checkOutput("lit_lw_101_req",   32'(bus.req), 0);

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h200, $urandom, 5, 0, 0);

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 2);
    step(1); @(negedge clk);
    checkOutput("lit_tmo_load_err", 32'(bus_err), 1);
    checkOutput("lit_tmo_load_wbv", 32'(wb_valid), 0);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h105, $urandom, 0, 0, 1);
    step(1); @(negedge clk);
    checkOutput("lit_tmo_store_err", 32'(bus_err), 1);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      if ($urandom_range(0, 9) < 9) begin
        if (rd && !wr) begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
          endcase
        end else begin
          f3 = 3'($urandom_range(0, 2));
        end
      end else begin
        f3 = 3'($urandom);
      end
      off = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(0, 3));
      a   = ($urandom_range(0, 255) << 2) | 32'(off);
      gd  = int'($urandom_range(0, 2));
      rvd = int'($urandom_range(0, 2));
      applyStimulus(rd, wr, f3, a, $urandom, gd, rvd, 0);
      if ($urandom_range(0, 3) == 0) step(1);
    end
    step(0);
    step(0);

    check_en = 1'b0;
    step(0);
    ex_valid = 1'b1; ex_memread = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h100;
    step(0);
    bus.gnt = 1'b1;
    step(0);
    reset = 1'b1;
    step(0);
    reset = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("rstwait_stall",  32'(lsu_stall), 0);
    checkOutput("rstwait_req",    32'(bus.req),   0);
    checkOutput("rstwait_wbv",    32'(wb_valid),  0);
    checkOutput("rstwait_rdata",  wb_rdata,       0);
    step(0);
    @(negedge clk);
    checkOutput("rstwait_wbv_late",   32'(wb_valid), 0);
    checkOutput("rstwait_rdata_late", wb_rdata,      0);
    exp_rdata = 32'h0;
    exp_fault = 0; exp_err = 0; exp_wb = 0;
    check_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 1, 0);
    step(1);
    step(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
